// File: rtl/dvi_init_seq.sv
// DVI transmitter power-up sequencer. It pulses the transmitter reset, waits for the part to
// settle, then writes a fixed register table over IIC and finally enables the timing generator.
module dvi_init_seq #(
  parameter int unsigned RST_HOLD      = 16,
  parameter int unsigned POST_RST_WAIT = 1024,
  parameter logic [6:0]  DEV_ADDR      = 7'h76,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       fbclk,
  input  logic       fbclk_rst_cause_b,
  input  logic       start,
  input  logic       reinit,
  output logic       iic_req,
  input  logic       iic_ack,
  input  logic       iic_xfer_done,
  input  logic       iic_nack,
  output logic [6:0] iic_dev_addr,
  output logic [7:0] iic_reg_addr,
  output logic [7:0] iic_wdata,
  output logic       dvi_reset_b,
  output logic       iic_done,
  output logic       tg_enable,
  output logic       init_error,
  output logic [2:0] retry_cnt
);

  typedef enum logic [2:0] {
    StIdle, StRstAssert, StRstWait, StIssue, StWaitXfer, StDone, StError
  } state_e;

  localparam logic [2:0]  LastIdx  = 3'd4;
  localparam logic [15:0] HoldLast = 16'(RST_HOLD - 1);
  localparam logic [15:0] WaitLast = 16'(POST_RST_WAIT - 1);
  localparam logic [2:0]  MaxRetry = 3'(MAX_RETRY);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic        xfer_end;

  assign iic_dev_addr = DEV_ADDR;

  always_comb begin
    iic_reg_addr = 8'h00;
    iic_wdata    = 8'h00;
    case (idx_q)
      3'd0: begin iic_reg_addr = 8'h49; iic_wdata = 8'hC0; end
      3'd1: begin iic_reg_addr = 8'h21; iic_wdata = 8'h09; end
      3'd2: begin iic_reg_addr = 8'h33; iic_wdata = 8'h06; end
      3'd3: begin iic_reg_addr = 8'h34; iic_wdata = 8'h26; end
      3'd4: begin iic_reg_addr = 8'h36; iic_wdata = 8'hA0; end
      default: ;
    endcase
  end

  // A completion arriving with the accept in ISSUE is handled as if already in WAIT_XFER.
  assign xfer_end = iic_xfer_done &
                    ((state_q == StWaitXfer) | ((state_q == StIssue) & iic_ack));

  always_ff @(posedge fbclk or negedge fbclk_rst_cause_b) begin
    if (!fbclk_rst_cause_b) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_cnt   <= '0;
      iic_req     <= 1'b0;
      dvi_reset_b <= 1'b0;
      iic_done    <= 1'b0;
      tg_enable   <= 1'b0;
      init_error  <= 1'b0;
    end else if ((state_q != StIdle) && !start) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_cnt   <= '0;
      iic_req     <= 1'b0;
      dvi_reset_b <= 1'b0;
      iic_done    <= 1'b0;
      tg_enable   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRstAssert;
            cnt_q   <= '0;
          end
        end
        StRstAssert: begin
          if (cnt_q == HoldLast) begin
            state_q     <= StRstWait;
            cnt_q       <= '0;
            dvi_reset_b <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StRstWait: begin
          if (cnt_q == WaitLast) begin
            state_q <= StIssue;
            cnt_q   <= '0;
            iic_req <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StIssue, StWaitXfer: begin
          if (xfer_end) begin
            if (!iic_nack) begin
              idx_q     <= idx_q + 3'd1;
              retry_cnt <= '0;
              if (idx_q == LastIdx) begin
                state_q   <= StDone;
                iic_req   <= 1'b0;
                iic_done  <= 1'b1;
                tg_enable <= 1'b1;
              end else begin
                state_q <= StIssue;
                iic_req <= 1'b1;
              end
            end else if (retry_cnt < MaxRetry) begin
              retry_cnt <= retry_cnt + 3'd1;
              state_q   <= StIssue;
              iic_req   <= 1'b1;
            end else begin
              state_q    <= StError;
              iic_req    <= 1'b0;
              init_error <= 1'b1;
            end
          end else if ((state_q == StIssue) && iic_ack) begin
            state_q <= StWaitXfer;
            iic_req <= 1'b0;
          end
        end
        StDone, StError: begin
          if (reinit) begin
            state_q     <= StRstAssert;
            cnt_q       <= '0;
            idx_q       <= '0;
            retry_cnt   <= '0;
            dvi_reset_b <= 1'b0;
            iic_done    <= 1'b0;
            tg_enable   <= 1'b0;
            init_error  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dvi_init_seq.sv
// Randomized bench for dvi_init_seq: a responsive IIC master plus a transaction-level model of
// the register table, retry budget and reset timing.
module tb_dvi_init_seq;

  localparam int unsigned RstHold     = 16;
  localparam int unsigned PostRstWait = 1024;
  localparam int unsigned MaxRetry    = 3;
  localparam logic [6:0]  DevAddr     = 7'h76;
  localparam int          NumEntries  = 5;
  localparam logic [7:0]  TblAddr [NumEntries] = '{8'h49, 8'h21, 8'h33, 8'h34, 8'h36};
  localparam logic [7:0]  TblData [NumEntries] = '{8'hC0, 8'h09, 8'h06, 8'h26, 8'hA0};

  logic       fbclk = 1'b0;
  logic       fbclk_rst_cause_b;
  logic       start, reinit, iic_ack, iic_xfer_done, iic_nack;
  logic       iic_req, dvi_reset_b, iic_done, tg_enable, init_error;
  logic [6:0] iic_dev_addr;
  logic [7:0] iic_reg_addr, iic_wdata;
  logic [2:0] retry_cnt;

  always #5 fbclk = ~fbclk;

  dvi_init_seq dut (
    .fbclk             (fbclk),
    .fbclk_rst_cause_b (fbclk_rst_cause_b),
    .start             (start),
    .reinit            (reinit),
    .iic_req           (iic_req),
    .iic_ack           (iic_ack),
    .iic_xfer_done     (iic_xfer_done),
    .iic_nack          (iic_nack),
    .iic_dev_addr      (iic_dev_addr),
    .iic_reg_addr      (iic_reg_addr),
    .iic_wdata         (iic_wdata),
    .dvi_reset_b       (dvi_reset_b),
    .iic_done          (iic_done),
    .tg_enable         (tg_enable),
    .init_error        (init_error),
    .retry_cnt         (retry_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_idx, m_retry;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_idx   = 0;
    m_retry = 0;
    m_err   = 1'b0;
  endtask

  // Caller raises start or reinit at a negedge; edge 1 is the first one sampling it.
  task automatic reset_phase();
    int low, req_at;
    bit seen_hi;
    low     = 0;
    req_at  = -1;
    seen_hi = 1'b0;
    for (int k = 1; k <= 3000 && req_at < 0; k++) begin
      @(negedge fbclk);
      if (k == 1) begin
        reinit = 1'b0;
        check("init_error_k1", 32'(init_error), 32'(0));
      end
      if (dvi_reset_b) seen_hi = 1'b1;
      else if (!seen_hi) low++;
      if (iic_req) req_at = k;
    end
    check("dvi_low_cycles", 32'(low), 32'(RstHold));
    check("first_req_cycle", 32'(req_at), 32'(1 + RstHold + PostRstWait));
  endtask

  task automatic do_write(input bit nack, input bit same);
    int w;
    w = 0;
    while (!iic_req && w < 200) begin
      @(negedge fbclk);
      w++;
    end
    if (!iic_req) begin
      check("req_timeout", 32'(0), 32'(1));
      return;
    end
    check("dev_addr", 32'(iic_dev_addr), 32'(DevAddr));
    check("reg_addr", 32'(iic_reg_addr), 32'(TblAddr[m_idx]));
    check("wdata", 32'(iic_wdata), 32'(TblData[m_idx]));
    check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    repeat ($urandom_range(0, 3)) @(negedge fbclk);
    check("req_held", 32'(iic_req), 32'(1));
    iic_ack = 1'b1;
    if (same) begin
      iic_xfer_done = 1'b1;
      iic_nack      = nack;
    end
    @(negedge fbclk);
    iic_ack       = 1'b0;
    iic_xfer_done = 1'b0;
    iic_nack      = 1'b0;
    if (!same) begin
      check("req_drop", 32'(iic_req), 32'(0));
      repeat ($urandom_range(0, 3)) @(negedge fbclk);
      iic_xfer_done = 1'b1;
      iic_nack      = nack;
      @(negedge fbclk);
      iic_xfer_done = 1'b0;
      iic_nack      = 1'b0;
    end
    if (!nack) begin
      m_idx++;
      m_retry = 0;
    end else if (m_retry < int'(MaxRetry)) begin
      m_retry++;
    end else begin
      m_err = 1'b1;
    end
    check("retry_after", 32'(retry_cnt), 32'(m_retry));
    check("iic_done", 32'(iic_done), 32'(m_idx == NumEntries));
    check("tg_enable", 32'(tg_enable), 32'(m_idx == NumEntries));
    check("init_error", 32'(init_error), 32'(m_err));
    check("req_next", 32'(iic_req), 32'(!m_err && m_idx < NumEntries));
  endtask

  task automatic run_all_random_nacks();
    bit nk;
    while (m_idx < NumEntries) begin
      nk = ($urandom_range(0, 3) == 0) && (m_retry < int'(MaxRetry));
      do_write(nk, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int reqs;
    fbclk_rst_cause_b = 1'b0;
    start = 1'b0; reinit = 1'b0;
    iic_ack = 1'b0; iic_xfer_done = 1'b0; iic_nack = 1'b0;
    model_clear();
    repeat (3) @(negedge fbclk);
    check("rst_req", 32'(iic_req), 32'(0));
    check("rst_dvi", 32'(dvi_reset_b), 32'(0));
    check("rst_done", 32'(iic_done), 32'(0));
    check("rst_tg", 32'(tg_enable), 32'(0));
    check("rst_err", 32'(init_error), 32'(0));
    check("rst_retry", 32'(retry_cnt), 32'(0));
    check("rst_regaddr", 32'(iic_reg_addr), 32'(8'h49));
    fbclk_rst_cause_b = 1'b1;

    // Stray completion while idle
    @(negedge fbclk);
    iic_xfer_done = 1'b1;
    @(negedge fbclk);
    iic_xfer_done = 1'b0;
    @(negedge fbclk);
    check("stray_req", 32'(iic_req), 32'(0));
    check("stray_regaddr", 32'(iic_reg_addr), 32'(8'h49));
    check("stray_dvi", 32'(dvi_reset_b), 32'(0));

    // Clean pass
    start = 1'b1;
    reset_phase();
    for (int i = 0; i < NumEntries; i++) do_write(1'b0, 1'($urandom_range(0, 1)));

    // Entry 2 NACKed twice, other entries randomly NACKed within budget
    reinit = 1'b1;
    model_clear();
    reset_phase();
    while (m_idx < 2) do_write(($urandom_range(0, 3) == 0) && (m_retry < int'(MaxRetry)), 1'b0);
    do_write(1'b1, 1'b0);
    do_write(1'b1, 1'b1);
    do_write(1'b0, 1'b0);
    run_all_random_nacks();

    // Entry 0 NACKed past the retry budget
    reinit = 1'b1;
    model_clear();
    reset_phase();
    for (int i = 0; i <= int'(MaxRetry); i++) do_write(1'b1, 1'($urandom_range(0, 1)));
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      iic_ack = (i == 3);
      @(negedge fbclk);
      if (iic_req) reqs++;
    end
    iic_ack = 1'b0;
    check("err_no_req", 32'(reqs), 32'(0));
    check("err_sticky", 32'(init_error), 32'(1));
    reinit = 1'b1;
    model_clear();
    reset_phase();

    // Drop start while waiting on entry 3
    for (int i = 0; i < 3; i++) do_write(1'b0, 1'b0);
    while (!iic_req) @(negedge fbclk);
    iic_ack = 1'b1;
    @(negedge fbclk);
    iic_ack = 1'b0;
    start   = 1'b0;
    @(negedge fbclk);
    check("drop_req", 32'(iic_req), 32'(0));
    check("drop_dvi", 32'(dvi_reset_b), 32'(0));
    check("drop_regaddr", 32'(iic_reg_addr), 32'(8'h49));
    check("drop_retry", 32'(retry_cnt), 32'(0));
    start = 1'b1;
    model_clear();
    reset_phase();
    run_all_random_nacks();

    // Asynchronous reset in the middle of the settle wait, between clock edges
    start = 1'b0;
    @(negedge fbclk);
    start = 1'b1;
    repeat (100) @(negedge fbclk);
    check("pre_arst_dvi", 32'(dvi_reset_b), 32'(1));
    #2 fbclk_rst_cause_b = 1'b0;
    #1;
    check("arst_dvi", 32'(dvi_reset_b), 32'(0));
    check("arst_req", 32'(iic_req), 32'(0));
    check("arst_done", 32'(iic_done), 32'(0));
    check("arst_tg", 32'(tg_enable), 32'(0));
    @(negedge fbclk);
    fbclk_rst_cause_b = 1'b1;
    model_clear();
    reset_phase();
    run_all_random_nacks();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
